// File: rtl/vector_uop_sequencer.sv
// rtl/vector_uop_sequencer.sv - splits one decoded vector instruction into element-group micro-ops
module vector_uop_sequencer #(
    parameter int VLEN  = 128,
    parameter int LANES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       vl,
    input  logic [7:0]       vstart,
    input  logic [1:0]       sew,
    input  logic [4:0]       vs1,
    input  logic [4:0]       vs2,
    input  logic [4:0]       vd,
    input  logic             vd_widen,
    input  logic             vs2_widen,
    input  logic             flush,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [4:0]       uop_vs1,
    output logic [4:0]       uop_vs2,
    output logic [4:0]       uop_vd,
    output logic [7:0]       uop_eidx,
    output logic [LANES-1:0] uop_lane_mask,
    output logic             uop_first,
    output logic             uop_last,
    output logic             instr_done,
    output logic             busy
);

    // log2 of elements per register at 8-bit EEW; wider EEWs shift by less
    localparam int         EPR8_SHIFT = $clog2(VLEN / 8);
    localparam logic [7:0] GROUP_MASK = ~8'(LANES - 1);
    localparam logic [8:0] LANES9     = 9'(LANES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state_q, state_d;
    logic [7:0] vl_q, vstart_q, eidx_q;
    logic [1:0] sew_q;
    logic [4:0] vs1_q, vs2_q, vd_q;
    logic       vd_widen_q, vs2_widen_q;
    logic       first_q;
    logic       done_q, done_d;

    logic       issuing;
    logic       empty;
    logic       last_grp;
    logic       accept;
    logic       advance;
    logic [2:0] eew_vs1, eew_vs2, eew_vd;

    function automatic logic [4:0] phys_reg(input logic [4:0] base,
                                            input logic [7:0] eidx,
                                            input logic [2:0] eew);
        logic [3:0] sh;
        sh = 4'(EPR8_SHIFT) - {1'b0, eew};
        return base + 5'(eidx >> sh);
    endfunction

    assign issuing  = (state_q == ISSUE);
    // vstart >= vl also covers vl == 0
    assign empty    = (vstart >= vl);
    assign last_grp = (({1'b0, eidx_q} + LANES9) >= {1'b0, vl_q});
    assign accept   = (state_q == IDLE) && instr_valid && !RST && !flush;
    assign advance  = issuing && uop_ready && !flush;

    assign eew_vs1 = {1'b0, sew_q};
    assign eew_vs2 = {1'b0, sew_q} + {2'b00, vs2_widen_q};
    assign eew_vd  = {1'b0, sew_q} + {2'b00, vd_widen_q};

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        instr_ready = (state_q == IDLE) && !RST;
        busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (empty) done_d = 1'b1;
                    else       state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (advance && last_grp) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uop_lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            uop_lane_mask[i] = issuing
                && (({1'b0, eidx_q} + 9'(i)) >= {1'b0, vstart_q})
                && (({1'b0, eidx_q} + 9'(i)) <  {1'b0, vl_q});
        end
    end

    // Outputs are gated so they read zero whenever nothing is being issued
    assign uop_valid  = issuing;
    assign uop_eidx   = issuing ? eidx_q : 8'd0;
    assign uop_vs1    = issuing ? phys_reg(vs1_q, eidx_q, eew_vs1) : 5'd0;
    assign uop_vs2    = issuing ? phys_reg(vs2_q, eidx_q, eew_vs2) : 5'd0;
    assign uop_vd     = issuing ? phys_reg(vd_q, eidx_q, eew_vd) : 5'd0;
    assign uop_first  = issuing && first_q;
    assign uop_last   = issuing && last_grp;
    assign instr_done = done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            first_q     <= 1'b0;
            eidx_q      <= 8'd0;
            vl_q        <= 8'd0;
            vstart_q    <= 8'd0;
            sew_q       <= 2'd0;
            vs1_q       <= 5'd0;
            vs2_q       <= 5'd0;
            vd_q        <= 5'd0;
            vd_widen_q  <= 1'b0;
            vs2_widen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                vl_q        <= vl;
                vstart_q    <= vstart;
                sew_q       <= sew;
                vs1_q       <= vs1;
                vs2_q       <= vs2;
                vd_q        <= vd;
                vd_widen_q  <= vd_widen;
                vs2_widen_q <= vs2_widen;
                eidx_q      <= vstart & GROUP_MASK;
                first_q     <= 1'b1;
            end else if (advance) begin
                eidx_q  <= eidx_q + 8'(LANES);
                first_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// tb/tb_vector_uop_sequencer.sv - randomized self-checking bench for vector_uop_sequencer
module tb_vector_uop_sequencer;

    localparam int VLEN  = 128;
    localparam int LANES = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [7:0]       vl = '0, vstart = '0;
    logic [1:0]       sew = '0;
    logic [4:0]       vs1 = '0, vs2 = '0, vd = '0;
    logic             vd_widen = 1'b0, vs2_widen = 1'b0, flush = 1'b0;
    logic             uop_valid;
    logic             uop_ready = 1'b0;
    logic [4:0]       uop_vs1, uop_vs2, uop_vd;
    logic [7:0]       uop_eidx;
    logic [LANES-1:0] uop_lane_mask;
    logic             uop_first, uop_last, instr_done, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int eidx;
        int r1;
        int r2;
        int rd;
        int mask;
        bit first;
        bit last;
    } uop_t;

    uop_t exp_q[$];

    vector_uop_sequencer #(.VLEN(VLEN), .LANES(LANES)) dut (
        .CLK(CLK), .RST(RST),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .vl(vl), .vstart(vstart), .sew(sew),
        .vs1(vs1), .vs2(vs2), .vd(vd),
        .vd_widen(vd_widen), .vs2_widen(vs2_widen), .flush(flush),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_vd(uop_vd),
        .uop_eidx(uop_eidx), .uop_lane_mask(uop_lane_mask),
        .uop_first(uop_first), .uop_last(uop_last),
        .instr_done(instr_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: elements per register = VLEN / element bits, groups aligned down to LANES
    function automatic void build_model(int m_vl, int m_vst, int m_sew, int m_r1, int m_r2,
                                        int m_rd, bit m_vdw, bit m_v2w);
        int start;
        uop_t u;
        exp_q.delete();
        if (m_vl == 0 || m_vst >= m_vl) return;
        start = (m_vst / LANES) * LANES;
        for (int e = start; e < m_vl; e += LANES) begin
            u.eidx  = e;
            u.r1    = (m_r1 + e / (VLEN / (8 << m_sew))) % 32;
            u.r2    = (m_r2 + e / (VLEN / (8 << (m_sew + int'(m_v2w))))) % 32;
            u.rd    = (m_rd + e / (VLEN / (8 << (m_sew + int'(m_vdw))))) % 32;
            u.mask  = 0;
            for (int i = 0; i < LANES; i++)
                if (e + i >= m_vst && e + i < m_vl) u.mask |= (1 << i);
            u.first = (e == start);
            u.last  = (e + LANES >= m_vl);
            exp_q.push_back(u);
        end
    endfunction

    task automatic send_instr(int l, int vst, int s, int r1, int r2, int rd, bit vdw, bit v2w);
        int w = 0;
        while (instr_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait instr_ready=%b required 1", instr_ready);
        end
        vl = 8'(l); vstart = 8'(vst); sew = 2'(s);
        vs1 = 5'(r1); vs2 = 5'(r2); vd = 5'(rd);
        vd_widen = vdw; vs2_widen = v2w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        build_model(l, vst, s, r1, r2, rd, vdw, v2w);
    endtask

    // Drains the expected micro-ops; optionally stalls stall_len cycles at micro-op stall_idx
    task automatic run_uops(int ready_pct, int stall_idx, int stall_len, string tag);
        int n = exp_q.size();
        int idx = 0;
        int cyc = 0;
        int stall_left = stall_len;
        bit stalled = 1'b0;
        logic [24+LANES:0] snap, prev;
        logic [24+LANES:0] got, want;
        prev = '0;
        if (n == 0) begin
            checks++;
            if ({instr_done, uop_valid, busy} !== 3'b100) begin
                errors++;
                $display("FAIL %s empty_done done/valid/busy=%b required 100", tag,
                         {instr_done, uop_valid, busy});
            end
            return;
        end
        while (idx < n && cyc < 400) begin
            snap = {uop_eidx, uop_vs1, uop_vs2, uop_vd, uop_lane_mask, uop_first, uop_last};
            checks++;
            if (uop_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s uop_valid_held got=%b required 1 at uop %0d", tag, uop_valid, idx);
                break;
            end
            if (stalled) begin
                checks++;
                if (snap !== prev) begin
                    errors++;
                    $display("FAIL %s stall_stable got=%h required %h", tag, snap, prev);
                end
            end
            if (idx == stall_idx && stall_left > 0) begin
                uop_ready = 1'b0;
                stall_left--;
            end else begin
                uop_ready = ($urandom_range(99, 0) < ready_pct);
            end
            if (uop_ready) begin
                got  = snap;
                want = {8'(exp_q[idx].eidx), 5'(exp_q[idx].r1), 5'(exp_q[idx].r2),
                        5'(exp_q[idx].rd), LANES'(exp_q[idx].mask),
                        exp_q[idx].first, exp_q[idx].last};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s uop%0d {eidx,vs1,vs2,vd,mask,first,last} got=%h required %h",
                             tag, idx, got, want);
                end
                idx++;
            end
            stalled = !uop_ready;
            prev = snap;
            step();
            cyc++;
        end
        uop_ready = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s uop_count got=%0d required %0d", tag, idx, n);
        end
        checks++;
        if ({instr_done, instr_ready, uop_valid, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL %s done_pulse done/ready/valid/busy=%b required 1100", tag,
                     {instr_done, instr_ready, uop_valid, busy});
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) step();
        checks++;
        if ({instr_ready, uop_valid, uop_first, uop_last, instr_done, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required 000000",
                     {instr_ready, uop_valid, uop_first, uop_last, instr_done, busy});
        end
        checks++;
        if ({uop_vs1, uop_vs2, uop_vd, uop_eidx, uop_lane_mask} !== '0) begin
            errors++;
            $display("FAIL reset_fields got=%h required 0",
                     {uop_vs1, uop_vs2, uop_vd, uop_eidx, uop_lane_mask});
        end
        RST = 1'b0;
        step();
        checks++;
        if ({instr_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release ready/busy=%b required 10", {instr_ready, busy});
        end
    endtask

    task automatic test_plan();
        send_instr(8, 0, 2, 4, 16, 8, 1'b0, 1'b0);
        run_uops(100, -1, 0, "plan_sew32");
        send_instr(5, 0, 2, 4, 16, 8, 1'b0, 1'b0);
        run_uops(100, -1, 0, "plan_tail");
        send_instr(6, 3, 3, 1, 2, 8, 1'b0, 1'b0);
        run_uops(100, -1, 0, "plan_vstart");
        send_instr(4, 0, 2, 4, 16, 8, 1'b1, 1'b0);
        run_uops(100, -1, 0, "plan_widen");
    endtask

    task automatic test_backpressure();
        send_instr(8, 0, 2, 4, 16, 8, 1'b0, 1'b0);
        run_uops(100, 1, 3, "backpressure");
    endtask

    task automatic test_empty();
        send_instr(0, 0, 1, 3, 3, 3, 1'b0, 1'b0);
        run_uops(100, -1, 0, "vl_zero");
        step();
        checks++;
        if (instr_done !== 1'b0) begin
            errors++;
            $display("FAIL vl_zero_single_pulse instr_done=%b required 0", instr_done);
        end
        send_instr(4, 4, 0, 3, 3, 3, 1'b0, 1'b0);
        run_uops(100, -1, 0, "vstart_ge_vl");
    endtask

    task automatic test_flush();
        send_instr(8, 0, 2, 4, 16, 8, 1'b0, 1'b0);
        uop_ready = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        uop_ready = 1'b0;
        checks++;
        if ({uop_valid, busy, instr_done} !== 3'b000) begin
            errors++;
            $display("FAIL flush_issue valid/busy/done=%b required 000", {uop_valid, busy, instr_done});
        end
        step();
        checks++;
        if (instr_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_done instr_done=%b required 0", instr_done);
        end
        vl = 8'd4; sew = 2'd2; instr_valid = 1'b1; flush = 1'b1;
        step();
        instr_valid = 1'b0; flush = 1'b0;
        checks++;
        if ({uop_valid, busy, instr_done} !== 3'b000) begin
            errors++;
            $display("FAIL flush_idle valid/busy/done=%b required 000", {uop_valid, busy, instr_done});
        end
        send_instr(5, 1, 1, 30, 31, 29, 1'b1, 1'b1);
        run_uops(70, -1, 0, "after_flush");
    endtask

    task automatic test_reset_mid();
        send_instr(8, 0, 2, 4, 16, 8, 1'b0, 1'b0);
        step();
        RST = 1'b1;
        step();
        checks++;
        if ({instr_ready, uop_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid ready/valid/busy=%b required 000", {instr_ready, uop_valid, busy});
        end
        RST = 1'b0;
        step();
        step();
        checks++;
        if ({instr_done, instr_ready, uop_valid} !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_after done/ready/valid=%b required 010",
                     {instr_done, instr_ready, uop_valid});
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            int s    = $urandom_range(3, 0);
            int vmax = (VLEN / (8 << s)) * 8;
            int l    = $urandom_range(vmax, 0);
            int vst  = $urandom_range(l + 2, 0);
            bit vdw  = (s <= 2) ? 1'($urandom_range(1, 0)) : 1'b0;
            bit v2w  = (s <= 2) ? 1'($urandom_range(1, 0)) : 1'b0;
            send_instr(l, vst, s, $urandom_range(31, 0), $urandom_range(31, 0),
                       $urandom_range(31, 0), vdw, v2w);
            run_uops($urandom_range(100, 30), $urandom_range(3, 0), $urandom_range(3, 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_backpressure();
        test_empty();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
